bus_timer: RTL and testbench

Memory-mapped 16-bit interval timer that acts as a bus responder on the 6502 SoC bus, alongside the RAM, GPIO and ACIA. It decodes a chip select from the top-level page decoder and returns read data registered one cycle later, matching the SoC data-mux timing. It raises a level interrupt on underflow, ORed into the CPU IRQ at top level.

---
 rtl/bus_timer_pkg.sv | 30 +++
 rtl/timer_prescaler.sv | 30 +++
 rtl/bus_timer.sv | 146 ++++++++++++++
 tb/tb_bus_timer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// rtl/bus_timer_pkg.sv - register map, bit indices and CTRL layout shared by the bus timer
package bus_timer_pkg;

    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_STAT = 3'd1;
    localparam logic [2:0] REG_PRE  = 3'd2;
    localparam logic [2:0] REG_RLO  = 3'd3;
    localparam logic [2:0] REG_RHI  = 3'd4;
    localparam logic [2:0] REG_CLO  = 3'd5;
    localparam logic [2:0] REG_CHI  = 3'd6;
    localparam logic [2:0] REG_CMP  = 3'd7;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;
    localparam int STAT_IF   = 0;
    localparam int STAT_RUN  = 1;

    // Field order mirrors the CTRL byte: ie is bit 2, en is bit 0.
    typedef struct packed {
        logic ie;
        logic auto_rl;
        logic en;
    } ctrl_t;

    function automatic logic [7:0] ctrl_byte(input ctrl_t c);
        ctrl_byte = {5'b00000, c};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divide-by-(divisor+1) tick generator for the bus timer
module timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_divisor,
    input  logic       i_enable,
    input  logic       i_reload,
    output logic       o_tick
);

    logic [7:0] r_cnt;

    // A reload on the same edge discards the tick.
    assign o_tick = i_enable & ~i_reload & (r_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (i_reload) begin
            r_cnt <= i_divisor;
        end else if (i_enable) begin
            if (r_cnt == 8'd0) begin
                r_cnt <= i_divisor;
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

endmodule

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - 6502 bus 16-bit interval timer with level irq
// TIMER_PWM_EN adds the CMP register at address 7 and the registered pwm_o output.
module bus_timer
    import bus_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    output logic       pwm_o
);

    ctrl_t       r_ctrl;
    logic        r_if;
    logic [7:0]  r_pre;
    logic [7:0]  r_rlo;
    logic [7:0]  r_rhi;
    logic [15:0] r_count;
    logic [7:0]  r_snap;
    logic [7:0]  r_dout;

    logic        w_wr;
    logic        w_rd;
    logic        w_rhi_wr;
    logic        w_tick;
    logic        w_underflow;
    logic [7:0]  w_rdata;

    assign w_wr        = cs & we;
    assign w_rd        = cs & ~we;
    assign w_rhi_wr    = w_wr && (addr == REG_RHI);
    assign w_underflow = w_tick && (r_count == 16'd0);

    timer_prescaler u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .i_divisor (r_pre),
        .i_enable  (r_ctrl.en),
        .i_reload  (w_rhi_wr),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= '0;
        end else if (w_wr && (addr == REG_CTRL)) begin
            r_ctrl <= din[2:0];
        end else if (w_underflow && !r_ctrl.auto_rl) begin
            r_ctrl.en <= 1'b0;
        end
    end

    // Underflow set has priority over a software clear on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if <= 1'b0;
        end else if (w_underflow) begin
            r_if <= 1'b1;
        end else if (w_wr && (addr == REG_STAT) && din[STAT_IF]) begin
            r_if <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= 8'd0;
            r_rlo <= 8'd0;
            r_rhi <= 8'd0;
        end else if (w_wr) begin
            if (addr == REG_PRE) r_pre <= din;
            if (addr == REG_RLO) r_rlo <= din;
            if (addr == REG_RHI) r_rhi <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (w_rhi_wr) begin
            r_count <= {din, r_rlo};
        end else if (w_tick) begin
            if (r_count != 16'd0) begin
                r_count <= r_count - 16'd1;
            end else if (r_ctrl.auto_rl) begin
                r_count <= {r_rhi, r_rlo};
            end
        end
    end

`ifdef TIMER_PWM_EN
    logic [7:0] r_cmp;
    logic       r_pwm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmp <= 8'd0;
            r_pwm <= 1'b0;
        end else begin
            if (w_wr && (addr == REG_CMP)) r_cmp <= din;
            r_pwm <= r_ctrl.en & (r_count < {8'h00, r_cmp});
        end
    end

    assign pwm_o = r_pwm;
`else
    assign pwm_o = 1'b0;
`endif

    always_comb begin
        w_rdata = 8'h00;
        case (addr)
            REG_CTRL: w_rdata = ctrl_byte(r_ctrl);
            REG_STAT: w_rdata = {6'b000000, r_ctrl.en, r_if};
            REG_PRE:  w_rdata = r_pre;
            REG_RLO:  w_rdata = r_rlo;
            REG_RHI:  w_rdata = r_rhi;
            REG_CLO:  w_rdata = r_count[7:0];
            REG_CHI:  w_rdata = r_snap;
`ifdef TIMER_PWM_EN
            REG_CMP:  w_rdata = r_cmp;
`else
            REG_CMP:  w_rdata = 8'h00;
`endif
            default:  w_rdata = 8'h00;
        endcase
    end

    // Every read cycle, dummy reads included, refreshes dout and CLO's snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= 8'h00;
            r_snap <= 8'h00;
        end else if (w_rd) begin
            r_dout <= w_rdata;
            if (addr == REG_CLO) r_snap <= r_count[15:8];
        end
    end

    assign dout = r_dout;
    assign irq  = r_if & r_ctrl.ie;

endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - scoreboard bench for bus_timer against a behavioural register model
module tb_bus_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;
    logic       pwm_o;

    always #5 clk = ~clk;

    bus_timer dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .irq   (irq),
        .pwm_o (pwm_o)
    );

    typedef struct packed {
        logic       is_rd;
        logic [7:0] dout;
        logic       irq;
        logic       pwm;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state: plain integers describing what software would observe.
    int m_en, m_auto, m_ie, m_if, m_pre, m_rlo, m_rhi;
    int m_count, m_wait, m_snap, m_dout, m_cmp;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // One bus cycle: drive at the falling edge, advance the model across the next rising edge.
    task automatic cyc(input bit rst, input bit c, input bit w, input int a, input int d);
        bit   rd, wr, rhi_wr, tick, under;
        int   rval, n_pwm;
        exp_t e;
        @(negedge clk);
        reset = rst;
        cs    = c;
        we    = w;
        addr  = a[2:0];
        din   = d[7:0];
        a     = a % 8;
        d     = d % 256;
        rd     = c && !w;
        wr     = c && w;
        rhi_wr = wr && (a == 4);
        tick   = (m_en != 0) && (m_wait == 0) && !rhi_wr;
        under  = tick && (m_count == 0);
        case (a)
            0: rval = m_en + 2 * m_auto + 4 * m_ie;
            1: rval = m_if + 2 * m_en;
            2: rval = m_pre;
            3: rval = m_rlo;
            4: rval = m_rhi;
            5: rval = m_count % 256;
            6: rval = m_snap;
            default: rval = m_cmp;
        endcase
`ifdef TIMER_PWM_EN
        n_pwm = (m_en != 0 && m_count < m_cmp) ? 1 : 0;
`else
        n_pwm = 0;
`endif
        if (rst) begin
            {m_en, m_auto, m_ie, m_if, m_pre, m_rlo, m_rhi} = '0;
            {m_count, m_wait, m_snap, m_dout, m_cmp} = '0;
            n_pwm = 0;
        end else begin
            if (rd) begin
                m_dout = rval;
                if (a == 5) m_snap = m_count / 256;
            end
            if (rhi_wr) begin
                m_count = d * 256 + m_rlo;
                m_wait  = m_pre;
            end else if (m_en != 0) begin
                m_wait = (m_wait == 0) ? m_pre : m_wait - 1;
                if (tick) begin
                    if (m_count > 0)         m_count = m_count - 1;
                    else if (m_auto != 0)    m_count = m_rhi * 256 + m_rlo;
                end
            end
            if (under) m_if = 1;
            else if (wr && a == 1 && d % 2 == 1) m_if = 0;
            if (under && m_auto == 0) m_en = 0;
            if (wr) begin
                case (a)
                    0: begin m_en = d % 2; m_auto = (d / 2) % 2; m_ie = (d / 4) % 2; end
                    2: m_pre = d;
                    3: m_rlo = d;
                    4: m_rhi = d;
`ifdef TIMER_PWM_EN
                    7: m_cmp = d;
`endif
                    default: ;
                endcase
            end
        end
        e.is_rd = rd && !rst;
        e.dout  = m_dout[7:0];
        e.irq   = (m_if != 0) && (m_ie != 0);
        e.pwm   = n_pwm[0];
        exp_q.push_back(e);
    endtask

    task automatic wr_reg(input int a, input int d);
        cyc(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd_reg(input int a);
        cyc(1'b0, 1'b1, 1'b0, a, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("irq", {15'd0, irq}, {15'd0, e.irq});
                chk("pwm_o", {15'd0, pwm_o}, {15'd0, e.pwm});
                if (e.is_rd) chk("dout", {8'd0, dout}, {8'd0, e.dout});
            end
        end
    end

    initial begin : stimulus
        int r, a, d;
        reset = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'd0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) rd_reg(i);
        idle(2);

        // One-shot: four ticks from count 3, then EN self-clears.
        wr_reg(2, 0); wr_reg(3, 3); wr_reg(4, 0); wr_reg(0, 5);
        idle(6);
        rd_reg(0); rd_reg(1); rd_reg(5);
        wr_reg(1, 1); wr_reg(1, 0);
        rd_reg(1);

        // Auto-reload with repeated STAT clears, some colliding with underflow.
        wr_reg(2, 1); wr_reg(3, 2); wr_reg(4, 0); wr_reg(0, 3);
        idle(20);
        for (int i = 0; i < 14; i++) wr_reg(1, 1);
        idle(4);
        rd_reg(1);

        // Snapshot survives the count rolling below 0x0100.
        wr_reg(0, 0); wr_reg(2, 3); wr_reg(3, 0); wr_reg(4, 1);
        rd_reg(5);
        wr_reg(0, 1);
        idle(10);
        rd_reg(6); rd_reg(5); rd_reg(6);

        // CTRL=0 on a tick cycle freezes the decremented count.
        wr_reg(2, 0); wr_reg(3, 8'h20); wr_reg(4, 0); wr_reg(0, 1);
        idle(5);
        wr_reg(0, 0);
        idle(3);
        rd_reg(5); rd_reg(5); rd_reg(0);

        // Compare output over several reload periods.
        wr_reg(7, 3); wr_reg(2, 0); wr_reg(3, 9); wr_reg(4, 0); wr_reg(0, 3);
        idle(32);
        rd_reg(7);
        wr_reg(0, 0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 299);
            a = $urandom_range(0, 7);
            d = $urandom_range(0, 255);
            if (a == 2) d = $urandom_range(0, 3);
            if (a == 4) d = $urandom_range(0, 1);
            if (a == 3 && d > 24) d = d % 24;
            if (r == 0)        cyc(1'b1, 1'b0, 1'b0, 0, 0);
            else if (r < 120)  idle(1);
            else if (r < 200)  rd_reg(a);
            else               wr_reg(a, d);
        end

        wr_reg(0, 0);
        idle(2);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", exp_q.size(), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
